// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
//
// Purpose: state encoding and line constants shared by the UART transmitter
//          and any receiver rework.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    GAP    = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6,
    DONE   = 3'd7
  } uart_state_e;

  // Start, parity and stop bits wrapped around the payload.
  localparam int UART_FRAME_OVERHEAD = 3;

  // Level of an idle (marking) line.
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - clks_per_bit down-counter producing a bit boundary strobe
//
// Purpose: free-running bit timer. bit_tick is high in the last cycle of each
//          bit period; load re-aligns the period to start on the next cycle.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (counter clears)
//   load     in   reload the counter to clks_per_bit-1
//   bit_tick out  high while the counter is 0 (every cycle when clks_per_bit=1)
module uart_baud_tick #(
  parameter int clks_per_bit = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_tick
);

  localparam int CW = $clog2(clks_per_bit) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(clks_per_bit - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign bit_tick = (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser with peer frame-start strobe
//
// Purpose: sends start, data (MSB first), parity and stop bits. tx_sof marks
//          the frame for the peer receiver; the start bit follows it by
//          exactly two cycles regardless of clks_per_bit.
// Ports:
//   clk       in   system clock
//   tx_enable in   synchronous active-high reset
//   tx_start  in   send request, sampled only in IDLE
//   tx_data   in   word captured on the accepting edge
//   tx_out    out  serial line, idles high
//   tx_sof    out  one-cycle frame-start strobe for the peer's rx_start
//   tx_busy   out  high from the accepting edge until frame completion
//   tx_done   out  one-cycle pulse after the stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int clks_per_bit = 1,
  parameter int parity_odd   = 0
) (
  input  logic                  clk,
  input  logic                  tx_enable,
  input  logic                  tx_start,
  input  logic [data_width-1:0] tx_data,
  output logic                  tx_out,
  output logic                  tx_sof,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IW = $clog2(data_width) + 1;
  localparam logic ODD = (parity_odd != 0);

  uart_state_e           state, state_next;
  logic [data_width-1:0] shreg;
  logic [IW-1:0]         bit_idx;
  logic                  parity_bit;
  logic                  bit_tick;
  logic                  line_bit;
  logic                  accept;

  // Reloading during GAP makes the first START cycle the first cycle of a
  // full bit period; afterwards the counter re-arms itself at each boundary.
  uart_baud_tick #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk     (clk),
    .rst     (tx_enable),
    .load    (state == GAP),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (tx_enable) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    line_bit   = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (tx_start) begin
          accept     = 1'b1;
          state_next = SOF;
        end
      end
      SOF:   state_next = GAP;
      GAP:   state_next = START;
      START: begin
        line_bit = 1'b0;
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        line_bit = shreg[data_width-1];
        if (bit_tick && bit_idx == '0) state_next = PARITY;
      end
      PARITY: begin
        line_bit = parity_bit;
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line, tx_sof and
  // tx_done all trail the state register by one cycle together.
  always_ff @(posedge clk) begin
    if (tx_enable) begin
      shreg      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx_out     <= UART_IDLE_LEVEL;
      tx_sof     <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      if (accept) begin
        shreg      <= tx_data;
        parity_bit <= (^tx_data) ^ ODD;
        tx_busy    <= 1'b1;
      end
      if (state == START && bit_tick) begin
        bit_idx <= IW'(data_width - 1);
      end
      if (state == DATA && bit_tick) begin
        shreg <= shreg << 1;
        if (bit_idx != '0) bit_idx <= bit_idx - IW'(1);
      end
      if (state == DONE) tx_busy <= 1'b0;
      tx_out  <= line_bit;
      tx_sof  <= (state == SOF);
      tx_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       en    [3];
  logic       start [3];
  logic [7:0] data  [3];
  logic       out   [3];
  logic       sof   [3];
  logic       busy  [3];
  logic       done  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.data_width(8), .clks_per_bit(1), .parity_odd(0)) dut_even (
    .clk(clk), .tx_enable(en[0]), .tx_start(start[0]), .tx_data(data[0]),
    .tx_out(out[0]), .tx_sof(sof[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_transmitter #(.data_width(8), .clks_per_bit(1), .parity_odd(1)) dut_odd (
    .clk(clk), .tx_enable(en[1]), .tx_start(start[1]), .tx_data(data[1]),
    .tx_out(out[1]), .tx_sof(sof[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_transmitter #(.data_width(8), .clks_per_bit(4), .parity_odd(0)) dut_os (
    .clk(clk), .tx_enable(en[2]), .tx_start(start[2]), .tx_data(data[2]),
    .tx_out(out[2]), .tx_sof(sof[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from just before the accepting edge (n=0) up to tx_done.
  // Captures the line like the peer receiver: first bit sampled 2 cycles
  // after tx_sof, one sample per bit, and counts cycles where a bit changed
  // within its period or tx_busy was wrong.
  task automatic run_frame(input int d, input int cpb, input bit keep, input int poke_at,
                           output logic [10:0] bits, output int sof_at, output int done_at,
                           output int hold_err, output int busy_err);
    logic q[$];
    int n;
    n = 0; sof_at = -1; done_at = -1; hold_err = 0; busy_err = 0; bits = '0;
    while (n < 200 && done_at < 0) begin
      tick();
      n++;
      if (n == 1 && !keep) start[d] = 1'b0;
      if (poke_at > 0 && n == poke_at) begin
        start[d] = 1'b1;
        data[d]  = 8'hFF;
      end
      if (poke_at > 0 && n == poke_at + 4) start[d] = 1'b0;
      q.push_back(out[d]);
      if (sof[d] === 1'b1 && sof_at < 0) sof_at = n;
      if (done[d] === 1'b1) begin
        done_at = n;
        if (busy[d] !== 1'b0) busy_err++;
      end else if (busy[d] !== 1'b1) begin
        busy_err++;
      end
    end
    if (sof_at > 0 && done_at > 0) begin
      for (int k = 0; k < 11; k++) begin
        for (int j = 0; j < cpb; j++) begin
          int idx;
          idx = sof_at + 2 + k * cpb + j - 1;
          if (idx < q.size()) begin
            if (j == 0) bits[10-k] = q[idx];
            else if (q[idx] !== bits[10-k]) hold_err++;
          end else begin
            hold_err++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b1; start[d] = 1'b0; data[d] = 8'h00;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) en[d] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({out[d], busy[d], sof[d], done[d]} !== 4'b1000) begin
          errors++;
          $display("FAIL reset_idle dut%0d cycle %0d: out/busy/sof/done=%b%b%b%b required 1000",
                   d, c, out[d], busy[d], sof[d], done[d]);
        end
      end
    end
  endtask

  task automatic test_basic_even();
    logic [10:0] bits;
    int sof_at, done_at, hold_err, busy_err;
    data[0] = 8'hA5; start[0] = 1'b1;
    run_frame(0, 1, 1'b0, 0, bits, sof_at, done_at, hold_err, busy_err);
    checks++;
    if (sof_at !== 2) begin
      errors++; $display("FAIL basic_sof_latency got %0d required 2", sof_at);
    end
    checks++;
    if (bits !== 11'b0_10100101_0_1) begin
      errors++; $display("FAIL basic_frame got %b required %b", bits, 11'b0_10100101_0_1);
    end
    checks++;
    if (done_at !== 15) begin
      errors++; $display("FAIL basic_done_latency got %0d required 15", done_at);
    end
    checks++;
    if (busy_err !== 0) begin
      errors++; $display("FAIL basic_busy got %0d bad cycles required 0", busy_err);
    end
    tick();
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse done=%b busy=%b required 0 0", done[0], busy[0]);
    end
  endtask

  task automatic test_odd_peer();
    logic [10:0] bits;
    int sof_at, done_at, hold_err, busy_err;
    data[1] = 8'h07; start[1] = 1'b1;
    run_frame(1, 1, 1'b0, 0, bits, sof_at, done_at, hold_err, busy_err);
    checks++;
    if (bits[1] !== 1'b0) begin
      errors++; $display("FAIL odd_parity_bit got %b required 0", bits[1]);
    end
    checks++;
    if (bits !== 11'b0_00000111_0_1) begin
      errors++; $display("FAIL odd_peer_frame got %b required %b", bits, 11'b0_00000111_0_1);
    end
    checks++;
    if (done_at !== 15) begin
      errors++; $display("FAIL odd_done_latency got %0d required 15", done_at);
    end
  endtask

  task automatic test_oversample_busy();
    logic [10:0] bits;
    int sof_at, done_at, hold_err, busy_err;
    int extra;
    data[2] = 8'h3C; start[2] = 1'b1;
    run_frame(2, 4, 1'b0, 20, bits, sof_at, done_at, hold_err, busy_err);
    checks++;
    if (sof_at !== 2) begin
      errors++; $display("FAIL os_sof_latency got %0d required 2", sof_at);
    end
    checks++;
    if (bits !== 11'b0_00111100_0_1) begin
      errors++; $display("FAIL os_frame got %b required %b", bits, 11'b0_00111100_0_1);
    end
    checks++;
    if (hold_err !== 0) begin
      errors++; $display("FAIL os_bit_hold got %0d unstable cycles required 0", hold_err);
    end
    checks++;
    if (done_at - 1 !== 47) begin
      errors++; $display("FAIL os_accept_to_done got %0d required 47", done_at - 1);
    end
    checks++;
    if (busy_err !== 0) begin
      errors++; $display("FAIL os_busy got %0d bad cycles required 0", busy_err);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sof[2] !== 1'b0 || busy[2] !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL os_ignored_request got %0d active cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    int sof_at, done_at, hold_err, busy_err;
    int stray;
    data[0] = 8'hA5; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    checks++;
    if ({out[0], busy[0], done[0], sof[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_state out/busy/done/sof=%b%b%b%b required 1000",
               out[0], busy[0], done[0], sof[0]);
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done[0] !== 1'b0 || out[0] !== 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL midreset_no_done got %0d stray cycles required 0", stray);
    end
    data[0] = 8'hA5; start[0] = 1'b1;
    run_frame(0, 1, 1'b0, 0, bits, sof_at, done_at, hold_err, busy_err);
    checks++;
    if (bits !== 11'b0_10100101_0_1 || done_at !== 15) begin
      errors++;
      $display("FAIL midreset_clean_frame got %b done %0d required %b done 15",
               bits, done_at, 11'b0_10100101_0_1);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1, bits2;
    int sof1, done1, hold1, busy1;
    int sof2, done2, hold2, busy2;
    data[0] = 8'h01; start[0] = 1'b1;
    run_frame(0, 1, 1'b1, 0, bits1, sof1, done1, hold1, busy1);
    data[0] = 8'h80;
    run_frame(0, 1, 1'b0, 0, bits2, sof2, done2, hold2, busy2);
    checks++;
    if (bits1 !== 11'b0_00000001_1_1) begin
      errors++; $display("FAIL b2b_frame1 got %b required %b", bits1, 11'b0_00000001_1_1);
    end
    checks++;
    if (bits2 !== 11'b0_10000000_1_1) begin
      errors++; $display("FAIL b2b_frame2 got %b required %b", bits2, 11'b0_10000000_1_1);
    end
    checks++;
    if (sof2 !== 2) begin
      errors++; $display("FAIL b2b_sof_after_done got %0d required 2", sof2);
    end
    checks++;
    if (done1 !== 15 || done2 !== 15) begin
      errors++; $display("FAIL b2b_done_latency got %0d/%0d required 15/15", done1, done2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_even();
    test_odd_peer();
    test_oversample_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one parallel word into a UART frame on a single line. The frame is a start bit, the data bits MSB first, a parity bit, and a stop bit.
- Emits a frame-start strobe, tx_sof, that drives rx_start of the peer UART_receiver.
- In bit-per-clock mode (clks_per_bit = 1) the frame is aligned so that the peer receiver samples correctly.
- Sits on the transmit side of the UART link, facing the existing receiver.

Parameters:
- data_width, 8: payload bits per frame.
- clks_per_bit, 1: clock cycles each line bit is held; legal range 1 to 65535.
- parity_odd, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- tx_enable  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send; sampled only in IDLE.
- tx_data  input  data_width  word to send; captured on the accepting edge.
- tx_out  output  1  serial line; idles high.
- tx_sof  output  1  one-cycle frame-start strobe, for the peer's rx_start.
- tx_busy  output  1  high from the accepting edge until frame completion.
- tx_done  output  1  one-cycle pulse after the stop bit.

Behaviour:
- Reset: clk only, tx_enable synchronous active-high. When tx_enable=1 at a rising edge:
  - state becomes IDLE;
  - tx_out=1, tx_sof=0, tx_busy=0, tx_done=0;
  - the shift register and counters clear.
- Reset has priority over all other inputs, including mid-frame. A reset mid-frame aborts the frame with no tx_done, and the line returns high the next cycle.
- All outputs are registered.
- States and transitions:
  - IDLE: tx_out=1. If tx_start=1, capture tx_data, compute parity, set tx_busy=1, go to SOF.
  - SOF: exactly one cycle. tx_sof=1, tx_out=1. Go to GAP.
  - GAP: exactly one cycle. tx_out=1. Go to START.
  - START: tx_out=0 for clks_per_bit cycles.
  - DATA: bits tx_data[data_width-1] down to tx_data[0], each held clks_per_bit cycles. A bit index counter of width clog2(data_width)+1 counts down; leave DATA when it reaches 0.
  - PARITY: tx_out = XOR of the data bits, XOR parity_odd. Held clks_per_bit cycles.
  - STOP: tx_out=1 for clks_per_bit cycles. Then go to DONE.
  - DONE: exactly one cycle. tx_done=1, tx_busy=0, tx_out=1. Go to IDLE.
- Peer alignment: the start bit is driven exactly 2 cycles after the tx_sof cycle, independent of clks_per_bit. This matches the receiver's IDLE→START→sample pipeline.
- Timing:
  - Frame line cycles = (data_width+3)·clks_per_bit.
  - From the accepting edge to tx_done high = 2 + (data_width+3)·clks_per_bit + 1 cycles.
- Bit timer:
  - Counter width is clog2(clks_per_bit)+1.
  - It reloads to clks_per_bit-1 at each bit boundary, and the bit advances when it reaches 0.
  - With clks_per_bit=1 the bit advances every cycle.
- tx_start while tx_busy=1 is ignored; there is no queueing.
- tx_data changes after acceptance do not affect the frame in flight.
- tx_start is not sampled in DONE. IDLE is re-entered one cycle later, so the minimum frame-to-frame spacing is DONE+IDLE.
- tx_start held high continuously sends back-to-back frames, each re-capturing tx_data.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, SOF, GAP, START, DATA, PARITY, STOP, DONE), shared with any receiver rework;
  - the frame overhead constant UART_FRAME_OVERHEAD = 3 (start, parity, stop);
  - the idle-line level constant (1).
- One natural sub-module: uart_baud_tick, the clks_per_bit down-counter producing a bit_tick strobe, reusable by a future oversampling receiver.
- The FSM and shift register stay in uart_transmitter.

Test Plan:
- Reset and idle: tx_enable=1 for 2 cycles, then no tx_start for 10 cycles → tx_out=1, tx_busy=0, tx_sof=0, tx_done=0 throughout.
- Basic frame, even parity: data_width=8, clks_per_bit=1, parity_odd=0, tx_data=8'hA5 →
  - tx_sof high 1 cycle after acceptance;
  - 2 cycles later tx_out = 0,1,0,1,0,0,1,0,1,0,1 (parity 0);
  - tx_done pulses the next cycle and tx_busy falls with it.
- Odd parity and a peer loop: parity_odd=1, tx_data=8'h07 →
  - parity bit = 0;
  - with tx_out→rx_in and tx_sof→rx_start of the receiver, the frame bits captured by the receiver equal the transmitted sequence.
- Oversampling and busy protection: clks_per_bit=4, tx_data=8'h3C; assert tx_start=1 with tx_data=8'hFF at mid-DATA →
  - each bit held exactly 4 cycles;
  - frame carries 8'h3C with parity 0 (even);
  - second request ignored; total accept-to-done 47 cycles.
- Reset mid-frame: start 8'hA5, assert tx_enable during bit 3 of DATA →
  - next cycle tx_out=1, tx_busy=0, and no tx_done pulse;
  - a subsequent tx_start sends a complete clean frame.
- Back-to-back: hold tx_start=1 with tx_data=8'h01, then 8'h80 →
  - two complete frames;
  - second tx_sof exactly 2 cycles after the first tx_done (DONE, then IDLE accept);
  - parity 1 for both.
